imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning the instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning the end-of-program marker word.
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port i_start  input  1  single-cycle pulse that starts a program load.
REQ-006 SHALL have port i_clear  input  1  single-cycle pulse that releases DONE back to IDLE.
REQ-007 SHALL have port i_rx_data  input  8  received byte, valid only while i_rx_valid is high.
REQ-008 SHALL have port i_rx_valid  input  1  one-cycle strobe marking a new byte.
REQ-009 SHALL have port o_imem_write_en  output  1  write strobe to instruction memory.
REQ-010 SHALL have port o_imem_addr  output  32  byte address of the word being written.
REQ-011 SHALL have port o_imem_data  output  32  word being written.
REQ-012 SHALL have port o_stall  output  1  holds the fetch stage while loading.
REQ-013 SHALL have port o_done  output  1  load finished.
REQ-014 SHALL have port o_overflow  output  1  load ended because memory was full, not on HALT_WORD.
REQ-015 SHALL have port o_word_count  output  32  number of words written in the current or last load.

Function
REQ-016 SHALL implement states IDLE, LOAD, WRITE and DONE.
REQ-017 In IDLE, i_start SHALL move the block to LOAD and clear the byte index, address, word count and o_overflow; i_rx_valid SHALL be ignored.
REQ-018 In LOAD, each i_rx_valid SHALL shift i_rx_data into the word assembly register, first byte as bits [31:24] (big-endian), and increment a 2-bit byte index.
REQ-019 When the fourth byte is accepted, the block SHALL enter WRITE on the next cycle.
REQ-020 WRITE SHALL last exactly one cycle, with o_imem_write_en=1, o_imem_data set to the assembled word and o_imem_addr set to the current address.
REQ-021 After WRITE, the address SHALL increment by 4 and o_word_count by 1.
REQ-022 After WRITE, the next state SHALL be DONE if the word equals HALT_WORD (the halt word is itself written) or o_word_count reaches MEM_DEPTH; otherwise it SHALL be LOAD.
REQ-023 Reaching MEM_DEPTH without HALT_WORD SHALL set o_overflow=1 in DONE.
REQ-024 An i_rx_valid arriving in the WRITE cycle SHALL be taken as byte 0 of the next word, unless the next state is DONE, in which case it SHALL be discarded.
REQ-025 o_stall SHALL be 1 in LOAD and WRITE and 0 in IDLE and DONE.
REQ-026 o_done SHALL be 1 only in DONE.
REQ-027 i_start SHALL be ignored in LOAD, WRITE and DONE.
REQ-028 i_clear in DONE SHALL move the block to IDLE, keeping o_word_count and o_overflow; i_clear in any other state SHALL be ignored.
REQ-029 o_imem_write_en SHALL never be high outside WRITE, and SHALL never be high for two consecutive cycles.
REQ-030 The address SHALL not wrap; DONE is forced before the address exceeds 4*(MEM_DEPTH-1).

Reset
REQ-031 While i_reset=0 at a clock edge, the block SHALL enter IDLE and zero o_imem_write_en, o_imem_addr, o_imem_data, o_stall, o_done, o_overflow, o_word_count, the byte index and the assembly register.
REQ-032 A reset in the middle of LOAD or WRITE SHALL abort the load with no further write strobe; any partial word SHALL be lost.

Structure
REQ-033 A shared package SHALL hold the state encoding (2-bit: IDLE=0, LOAD=1, WRITE=2, DONE=3), the HALT_WORD default and the word/byte width constants.
REQ-034 The byte-to-word assembler SHALL be a single sub-module, word_assembler: a shift register plus byte index, with a word-ready output.
REQ-035 The FSM, address counter and word counter SHALL stay in the top level.

Verification
REQ-036 Start, then bytes 20,08,00,05 -> one write strobe with data=32'h20080005, addr=0; word_count=1; o_stall=1.
REQ-037 Start, then 2 words followed by FF,FF,FF,FF -> writes at addrs 0, 4 and 8 (the last with data FFFFFFFF); o_done=1; word_count=3; o_overflow=0; o_stall=0.
REQ-038 MEM_DEPTH=4, five non-halt words sent -> exactly 4 writes (last addr=12); o_done=1; o_overflow=1; the fifth word is ignored.
REQ-039 Reset asserted after 2 bytes of a word -> next cycle IDLE with all outputs zero; a subsequent start reloads from addr 0.
REQ-040 Byte arriving in the WRITE cycle, plus i_start pulsed during LOAD -> the byte appears as bits [31:24] of the next word; i_start has no effect.
REQ-041 Bytes in IDLE and DONE -> no write; i_clear in DONE -> IDLE with word_count retained.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: state encoding,
// word/byte widths and the default end-of-program marker.
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Received-byte stream bundle: one data byte qualified by a valid strobe.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word shift register with a 2-bit byte index; word_ready
// flags the cycle in which the fourth byte of a word is being accepted.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  imem_loader_if.slave      rx,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;

  // Shifting left means the first byte of a word ends up in bits [31:24].
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (rx.rx_valid) begin
      word_d = {word_q[WORD_W-BYTE_W-1:0], rx.rx_data};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word       = word_q;
  assign word_ready = rx.rx_valid && (idx_q == 2'd3) && !clear;

endmodule

// File: rtl/imem_loader.sv
// Loads a program received byte-by-byte into instruction memory, one 32-bit
// word per write strobe, stopping on the halt word or when memory is full.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                MEM_DEPTH = 256,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_imem_write_en,
  output logic [WORD_W-1:0] o_imem_addr,
  output logic [WORD_W-1:0] o_imem_data,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_overflow,
  output logic [WORD_W-1:0] o_word_count
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              clear_asm;
  logic              accept;
  logic              word_ready;
  logic [WORD_W-1:0] asm_word;
  logic              is_halt;
  logic              mem_full;
  logic              last_write;

  imem_loader_if rx_bus ();

  assign is_halt    = (asm_word == HALT_WORD);
  assign mem_full   = ((cnt_q + 32'd1) == 32'(MEM_DEPTH));
  assign last_write = is_halt || mem_full;

  // A byte landing in the WRITE cycle starts the next word, unless this write ends the load.
  assign accept    = (state_q == ST_LOAD) || ((state_q == ST_WRITE) && !last_write);
  assign clear_asm = (state_q == ST_IDLE) && i_start;

  assign rx_bus.rx_data  = i_rx_data;
  assign rx_bus.rx_valid = i_rx_valid && accept;

  word_assembler u_asm (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .clear      (clear_asm),
    .rx         (rx_bus.slave),
    .word       (asm_word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (word_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        addr_d = addr_q + 32'd4;
        cnt_d  = cnt_q + 32'd1;
        if (last_write) begin
          state_d = ST_DONE;
          ovf_d   = mem_full && !is_halt;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        if (i_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_imem_write_en = (state_q == ST_WRITE);
  assign o_imem_addr     = addr_q;
  assign o_imem_data     = o_imem_write_en ? asm_word : '0;
  assign o_stall         = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign o_done          = (state_q == ST_DONE);
  assign o_overflow      = ovf_q;
  assign o_word_count    = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-depth instance plus a 4-word
// instance sharing the same stimulus, with write strobes logged per instance.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic i_clk;
  logic i_reset;
  logic i_start;
  logic i_clear;

  imem_loader_if stim ();

  logic        we_a, ovf_a, stall_a, done_a;
  logic [31:0] addr_a, data_a, cnt_a;
  logic        we_b, ovf_b, stall_b, done_b;
  logic [31:0] addr_b, data_b, cnt_b;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [31:0] log_addr_a[$];
  logic [31:0] log_data_a[$];
  logic [31:0] log_addr_b[$];
  int          dbl_strobe = 0;
  logic        prev_we_a  = 1'b0;
  logic        prev_we_b  = 1'b0;

  imem_loader dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_clear         (i_clear),
    .i_rx_data       (stim.rx_data),
    .i_rx_valid      (stim.rx_valid),
    .o_imem_write_en (we_a),
    .o_imem_addr     (addr_a),
    .o_imem_data     (data_a),
    .o_stall         (stall_a),
    .o_done          (done_a),
    .o_overflow      (ovf_a),
    .o_word_count    (cnt_a)
  );

  imem_loader #(.MEM_DEPTH(4)) dut_small (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_clear         (i_clear),
    .i_rx_data       (stim.rx_data),
    .i_rx_valid      (stim.rx_valid),
    .o_imem_write_en (we_b),
    .o_imem_addr     (addr_b),
    .o_imem_data     (data_b),
    .o_stall         (stall_b),
    .o_done          (done_b),
    .o_overflow      (ovf_b),
    .o_word_count    (cnt_b)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Write strobes are captured mid-cycle, away from the rising edge.
  always @(negedge i_clk) begin
    if (we_a) begin
      log_addr_a.push_back(addr_a);
      log_data_a.push_back(data_a);
    end
    if (we_b) log_addr_b.push_back(addr_b);
    if ((we_a && prev_we_a) || (we_b && prev_we_b)) dbl_strobe++;
    prev_we_a = we_a;
    prev_we_b = we_b;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    stim.rx_data  = b;
    stim.rx_valid = 1'b1;
    tick();
    stim.rx_valid = 1'b0;
    stim.rx_data  = 8'h00;
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[31:24]);
    applyStimulus(w[23:16]);
    applyStimulus(w[15:8]);
    applyStimulus(w[7:0]);
    tick();
  endtask

  task automatic pulseStart();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic pulseClear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic doReset();
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    log_addr_a.delete();
    log_data_a.delete();
    log_addr_b.delete();
  endtask

  initial begin
    int n;
    i_reset       = 1'b0;
    i_start       = 1'b0;
    i_clear       = 1'b0;
    stim.rx_data  = 8'h00;
    stim.rx_valid = 1'b0;
    tick();
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_we",    {31'd0, we_a},    32'd0);
    checkOutput("rst_addr",  addr_a,           32'd0);
    checkOutput("rst_data",  data_a,           32'd0);
    checkOutput("rst_stall", {31'd0, stall_a}, 32'd0);
    checkOutput("rst_done",  {31'd0, done_a},  32'd0);
    checkOutput("rst_ovf",   {31'd0, ovf_a},   32'd0);
    checkOutput("rst_cnt",   cnt_a,            32'd0);

    $display("[TB] single word");
    pulseStart();
    checkOutput("w1_stall_load", {31'd0, stall_a}, 32'd1);
    applyStimulus(8'h20);
    applyStimulus(8'h08);
    applyStimulus(8'h00);
    checkOutput("w1_no_early_we", {31'd0, we_a}, 32'd0);
    applyStimulus(8'h05);
    checkOutput("w1_we",    {31'd0, we_a}, 32'd1);
    checkOutput("w1_data",  data_a,        32'h2008_0005);
    checkOutput("w1_addr",  addr_a,        32'd0);
    tick();
    checkOutput("w1_we_low", {31'd0, we_a},    32'd0);
    checkOutput("w1_cnt",    cnt_a,            32'd1);
    checkOutput("w1_stall",  {31'd0, stall_a}, 32'd1);

    $display("[TB] halt-terminated program");
    doReset();
    pulseStart();
    sendWord(32'h1122_3344);
    sendWord(32'hAABB_CCDD);
    sendWord(32'hFFFF_FFFF);
    n = log_addr_a.size();
    checkOutput("halt_nwrites", n, 32'd3);
    if (n == 3) begin
      checkOutput("halt_addr0", log_addr_a[0], 32'd0);
      checkOutput("halt_data0", log_data_a[0], 32'h1122_3344);
      checkOutput("halt_addr1", log_addr_a[1], 32'd4);
      checkOutput("halt_data1", log_data_a[1], 32'hAABB_CCDD);
      checkOutput("halt_addr2", log_addr_a[2], 32'd8);
      checkOutput("halt_data2", log_data_a[2], 32'hFFFF_FFFF);
    end
    checkOutput("halt_done",  {31'd0, done_a},  32'd1);
    checkOutput("halt_cnt",   cnt_a,            32'd3);
    checkOutput("halt_ovf",   {31'd0, ovf_a},   32'd0);
    checkOutput("halt_stall", {31'd0, stall_a}, 32'd0);

    $display("[TB] memory-full overflow on 4-word instance");
    doReset();
    pulseStart();
    for (int i = 0; i < 5; i++) sendWord(32'h0102_0304 + 32'(i) * 32'h1010_1010);
    n = log_addr_b.size();
    checkOutput("ovf_nwrites", n, 32'd4);
    if (n == 4) checkOutput("ovf_last_addr", log_addr_b[3], 32'd12);
    checkOutput("ovf_done",  {31'd0, done_b},  32'd1);
    checkOutput("ovf_flag",  {31'd0, ovf_b},   32'd1);
    checkOutput("ovf_cnt",   cnt_b,            32'd4);
    checkOutput("ovf_stall", {31'd0, stall_b}, 32'd0);

    $display("[TB] reset mid-word");
    doReset();
    pulseStart();
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    doReset();
    checkOutput("mid_we",    {31'd0, we_a},    32'd0);
    checkOutput("mid_stall", {31'd0, stall_a}, 32'd0);
    checkOutput("mid_done",  {31'd0, done_a},  32'd0);
    checkOutput("mid_cnt",   cnt_a,            32'd0);
    checkOutput("mid_addr",  addr_a,           32'd0);
    checkOutput("mid_data",  data_a,           32'd0);
    applyStimulus(8'h56);
    applyStimulus(8'h78);
    tick();
    checkOutput("mid_idle_nwrites", log_addr_a.size(), 32'd0);
    pulseStart();
    applyStimulus(8'hCA);
    applyStimulus(8'hFE);
    applyStimulus(8'hF0);
    applyStimulus(8'h0D);
    checkOutput("mid_reload_we",   {31'd0, we_a}, 32'd1);
    checkOutput("mid_reload_data", data_a,        32'hCAFE_F00D);
    checkOutput("mid_reload_addr", addr_a,        32'd0);

    $display("[TB] byte in WRITE cycle, start during LOAD");
    doReset();
    pulseStart();
    applyStimulus(8'hA1);
    i_start = 1'b1;
    applyStimulus(8'hB2);
    i_start = 1'b0;
    applyStimulus(8'hC3);
    applyStimulus(8'hD4);
    checkOutput("wb_we0",   {31'd0, we_a}, 32'd1);
    checkOutput("wb_data0", data_a,        32'hA1B2_C3D4);
    checkOutput("wb_addr0", addr_a,        32'd0);
    applyStimulus(8'h5E);
    applyStimulus(8'h6F);
    applyStimulus(8'h70);
    applyStimulus(8'h81);
    checkOutput("wb_data1", data_a,        32'h5E6F_7081);
    checkOutput("wb_addr1", addr_a,        32'd4);
    tick();
    checkOutput("wb_cnt",   cnt_a,         32'd2);

    $display("[TB] ignored bytes in DONE and IDLE, clear");
    sendWord(32'hFFFF_FFFF);
    checkOutput("dn_done", {31'd0, done_a}, 32'd1);
    n = log_addr_a.size();
    sendWord(32'h9999_9999);
    pulseStart();
    checkOutput("dn_nwrites", log_addr_a.size(), 32'(n));
    checkOutput("dn_still_done", {31'd0, done_a}, 32'd1);
    pulseClear();
    checkOutput("clr_done",  {31'd0, done_a},  32'd0);
    checkOutput("clr_stall", {31'd0, stall_a}, 32'd0);
    checkOutput("clr_cnt",   cnt_a,            32'd3);
    sendWord(32'h7777_7777);
    pulseClear();
    checkOutput("idle_nwrites", log_addr_a.size(), 32'(n));
    checkOutput("idle_cnt",     cnt_a,             32'd3);
    checkOutput("idle_stall",   {31'd0, stall_a},  32'd0);

    checkOutput("no_double_strobe", dbl_strobe, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
